// File: rtl/evt_debounce_pulser.sv
// Event-line qualifier: synchronises evt_in, debounces it over DEB_CYCLES stable
// samples, emits a one-cycle pulse per accepted edge and counts aborted qualifications.
module evt_debounce_pulser #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = 4,
   parameter int unsigned EDGE        = 0,
   parameter int unsigned GW          = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          evt_in,
   input  logic          glitch_clr,
   output logic          level,
   output logic          en_pulse,
   output logic [GW-1:0] glitch_cnt
);

   localparam int unsigned   QW         = $clog2(DEB_CYCLES + 1);
   localparam logic [QW-1:0] QMAX       = QW'(DEB_CYCLES);
   localparam logic [GW-1:0] GMAX       = '1;
   localparam logic          PULSE_RISE = (EDGE == 0) || (EDGE == 2);
   localparam logic          PULSE_FALL = (EDGE == 1) || (EDGE == 2);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_QUAL   = 1'b1
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s;
   state_e                 state_q, state_d;
   logic [QW-1:0]          qcnt_q, qcnt_d;
   logic                   level_q, level_d;
   logic                   en_pulse_q, en_pulse_d;
   logic [GW-1:0]          glitch_cnt_q, glitch_cnt_d;
   logic                   accept;
   logic                   abort;

   // Plain shift chain; s is the last stage.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], evt_in};
      s      = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= '0;
         state_q      <= ST_STABLE;
         qcnt_q       <= '0;
         level_q      <= 1'b0;
         en_pulse_q   <= 1'b0;
         glitch_cnt_q <= '0;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         qcnt_q       <= qcnt_d;
         level_q      <= level_d;
         en_pulse_q   <= en_pulse_d;
         glitch_cnt_q <= glitch_cnt_d;
      end
   end

   // Qualification FSM: qcnt holds the number of consecutive samples with s != level.
   always_comb begin
      state_d      = state_q;
      qcnt_d       = qcnt_q;
      level_d      = level_q;
      en_pulse_d   = 1'b0;
      glitch_cnt_d = glitch_cnt_q;
      accept       = 1'b0;
      abort        = 1'b0;

      case (state_q)
         ST_STABLE: begin
            if (s != level_q) begin
               if (DEB_CYCLES == 1) begin
                  accept = 1'b1;
               end else begin
                  state_d = ST_QUAL;
                  qcnt_d  = QW'(1);
               end
            end
         end
         ST_QUAL: begin
            if (s == level_q) begin
               abort   = 1'b1;
               state_d = ST_STABLE;
               qcnt_d  = '0;
            end else if ((qcnt_q + QW'(1)) == QMAX) begin
               accept  = 1'b1;
               state_d = ST_STABLE;
               qcnt_d  = '0;
            end else if (qcnt_q != QMAX) begin
               qcnt_d = qcnt_q + QW'(1);
            end
         end
         default: begin
            state_d = ST_STABLE;
            qcnt_d  = '0;
         end
      endcase

      if (accept) begin
         level_d    = ~level_q;
         en_pulse_d = level_d ? PULSE_RISE : PULSE_FALL;
      end

      // Clear has priority; the increment stops at all-ones.
      if (glitch_clr) begin
         glitch_cnt_d = '0;
      end else if (abort && (glitch_cnt_q != GMAX)) begin
         glitch_cnt_d = glitch_cnt_q + GW'(1);
      end
   end

   assign level      = level_q;
   assign en_pulse   = en_pulse_q;
   assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_evt_debounce_pulser.sv
// Bench for evt_debounce_pulser: three parameterisations checked every cycle against
// a sample-history reference model, plus directed latency/saturation scenarios.
module tb_evt_debounce_pulser;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       evt_a, evt_b, evt_c;
   logic       clr_a, clr_b, clr_c;
   logic       level_a, level_b, level_c;
   logic       pulse_a, pulse_b, pulse_c;
   logic [7:0] gcnt_a, gcnt_b, gcnt_c;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state, index 0/1/2 = instance a/b/c.
   int m_n   [3];
   int m_run [3];
   int m_gl  [3];
   bit m_lvl [3];
   bit m_pls [3];
   bit m_hist[3][64];

   int a_pulses = 0;
   int cnt4     = 0;
   bit prev_a   = 1'b0;
   bit prev_c   = 1'b0;

   always #5 clk = ~clk;

   evt_debounce_pulser #(.SYNC_STAGES(2), .DEB_CYCLES(4), .EDGE(0), .GW(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .evt_in(evt_a), .glitch_clr(clr_a),
      .level(level_a), .en_pulse(pulse_a), .glitch_cnt(gcnt_a));

   evt_debounce_pulser #(.SYNC_STAGES(2), .DEB_CYCLES(1), .EDGE(2), .GW(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .evt_in(evt_b), .glitch_clr(clr_b),
      .level(level_b), .en_pulse(pulse_b), .glitch_cnt(gcnt_b));

   evt_debounce_pulser #(.SYNC_STAGES(3), .DEB_CYCLES(3), .EDGE(1), .GW(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .evt_in(evt_c), .glitch_clr(clr_c),
      .level(level_c), .en_pulse(pulse_c), .glitch_cnt(gcnt_c));

   function automatic int sync_of(input int i);
      return (i == 2) ? 3 : 2;
   endfunction

   function automatic int deb_of(input int i);
      return (i == 0) ? 4 : ((i == 1) ? 1 : 3);
   endfunction

   function automatic int edge_of(input int i);
      return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // One clock of the debouncing rules: a run of differing samples reaching deb
   // accepts the edge; a run ended early by agreement counts as one glitch.
   function automatic void mdl_step(input int deb, input int edge_sel, input bit s,
                                    input bit clr, inout bit lvl, inout int run,
                                    inout int gl, output bit pulse);
      pulse = 1'b0;
      if (s != lvl) begin
         run++;
         if (run == deb) begin
            lvl   = !lvl;
            run   = 0;
            pulse = (edge_sel == 2) || (edge_sel == 0 && lvl) || (edge_sel == 1 && !lvl);
         end
      end else begin
         if (run > 0 && gl < 255) gl++;
         run = 0;
      end
      if (clr) gl = 0;
   endfunction

   task automatic tick();
      bit ev[3];
      bit cl[3];
      bit s, lvl, pls;
      int run, gl, sy;
      @(posedge clk);
      ev[0] = evt_a; ev[1] = evt_b; ev[2] = evt_c;
      cl[0] = clr_a; cl[1] = clr_b; cl[2] = clr_c;
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            m_n[i] = 0; m_run[i] = 0; m_gl[i] = 0; m_lvl[i] = 1'b0; m_pls[i] = 1'b0;
         end else begin
            m_n[i]++;
            sy = sync_of(i);
            m_hist[i][m_n[i] % 64] = ev[i];
            s = (m_n[i] > sy) ? m_hist[i][(m_n[i] - sy) % 64] : 1'b0;
            lvl = m_lvl[i]; run = m_run[i]; gl = m_gl[i];
            mdl_step(deb_of(i), edge_of(i), s, cl[i], lvl, run, gl, pls);
            m_lvl[i] = lvl; m_run[i] = run; m_gl[i] = gl; m_pls[i] = pls;
         end
      end
      @(negedge clk);
      chk("a_level", 32'(level_a), 32'(m_lvl[0]));
      chk("a_pulse", 32'(pulse_a), 32'(m_pls[0]));
      chk("a_gcnt",  32'(gcnt_a),  32'(m_gl[0]));
      chk("b_level", 32'(level_b), 32'(m_lvl[1]));
      chk("b_pulse", 32'(pulse_b), 32'(m_pls[1]));
      chk("b_gcnt",  32'(gcnt_b),  32'(m_gl[1]));
      chk("c_level", 32'(level_c), 32'(m_lvl[2]));
      chk("c_pulse", 32'(pulse_c), 32'(m_pls[2]));
      chk("c_gcnt",  32'(gcnt_c),  32'(m_gl[2]));
      chk("a_pulse_adjacent", 32'(pulse_a & prev_a), 32'd0);
      chk("c_pulse_adjacent", 32'(pulse_c & prev_c), 32'd0);
      prev_a = pulse_a;
      prev_c = pulse_c;
      if (pulse_a) begin
         a_pulses++;
         if (cnt4 < 15) cnt4++;
      end
   endtask

   // evt_a high for 3 clocks, low for 5; abort lands on the 6th clock.
   task automatic glitch_a(input int clr_at);
      for (int k = 1; k <= 8; k++) begin
         evt_a = (k <= 3);
         clr_a = (k == clr_at);
         tick();
      end
      clr_a = 1'b0;
      evt_a = 1'b0;
   endtask

   initial begin
      int lat, np, hold_a, hold_b, hold_c;
      rst_n = 1'b0;
      evt_a = 1'b0; evt_b = 1'b0; evt_c = 1'b0;
      clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      chk("rst_level", 32'(level_a), 32'd0);
      chk("rst_pulse", 32'(pulse_a), 32'd0);
      chk("rst_gcnt",  32'(gcnt_a),  32'd0);

      // Quiet line.
      a_pulses = 0;
      repeat (20) tick();
      chk("quiet_pulses", 32'(a_pulses), 32'd0);
      chk("quiet_gcnt",   32'(gcnt_a),   32'd0);

      // Clean rise then fall on defaults.
      evt_a = 1'b1; a_pulses = 0; lat = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (pulse_a && lat == 0) lat = k;
      end
      chk("rise_latency", 32'(lat), 32'd6);
      chk("rise_pulses",  32'(a_pulses), 32'd1);
      chk("rise_level",   32'(level_a), 32'd1);
      evt_a = 1'b0; a_pulses = 0; lat = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (!level_a && lat == 0) lat = k;
      end
      chk("fall_latency", 32'(lat), 32'd6);
      chk("fall_pulses",  32'(a_pulses), 32'd0);

      // Short glitches and saturation.
      a_pulses = 0;
      glitch_a(0);
      chk("glitch_one",    32'(gcnt_a), 32'd1);
      chk("glitch_level",  32'(level_a), 32'd0);
      chk("glitch_pulses", 32'(a_pulses), 32'd0);
      for (int g = 0; g < 299; g++) glitch_a(0);
      chk("glitch_sat", 32'(gcnt_a), 32'd255);
      glitch_a(6);
      chk("glitch_clr_wins", 32'(gcnt_a), 32'd0);

      // DEB_CYCLES=1, both edges: every toggle pulses 3 clocks later.
      for (int t = 0; t < 5; t++) begin
         evt_b = !evt_b; lat = 0; np = 0;
         for (int k = 1; k <= 4; k++) begin
            tick();
            if (pulse_b) begin
               np++;
               if (lat == 0) lat = k;
            end
         end
         chk("b_toggle_latency", 32'(lat), 32'd3);
         chk("b_toggle_pulses",  32'(np),  32'd1);
      end
      evt_b = 1'b0;
      repeat (4) tick();

      // Downstream 4-bit saturating counter fed by en_pulse.
      a_pulses = 0; cnt4 = 0;
      for (int e = 0; e < 20; e++) begin
         evt_a = 1'b1; repeat (8) tick();
         evt_a = 1'b0; repeat (8) tick();
      end
      chk("cnt4_saturated", 32'(cnt4), 32'd15);
      chk("pulse_count_20", 32'(a_pulses), 32'd20);

      // Reset during qualification discards progress.
      a_pulses = 0;
      evt_a = 1'b1;
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      chk("rst_mid_pulses", 32'(a_pulses), 32'd0);
      chk("rst_mid_level",  32'(level_a), 32'd0);
      rst_n = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (pulse_a && lat == 0) lat = k;
      end
      chk("rst_release_latency", 32'(lat), 32'd6);
      chk("rst_release_pulses",  32'(a_pulses), 32'd1);
      chk("rst_release_gcnt",    32'(gcnt_a), 32'd0);

      // Randomised lines on all three instances.
      hold_a = 0; hold_b = 0; hold_c = 0;
      for (int c = 0; c < 2500; c++) begin
         if (hold_a == 0) begin evt_a = 1'($urandom_range(0, 1)); hold_a = int'($urandom_range(1, 10)); end
         if (hold_b == 0) begin evt_b = 1'($urandom_range(0, 1)); hold_b = int'($urandom_range(1, 10)); end
         if (hold_c == 0) begin evt_c = 1'($urandom_range(0, 1)); hold_c = int'($urandom_range(1, 10)); end
         hold_a--; hold_b--; hold_c--;
         clr_a = ($urandom_range(0, 63) == 0);
         clr_b = ($urandom_range(0, 63) == 0);
         clr_c = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
